// File: rtl/addsub_pkg.sv
// Shared definitions for the 4-bit adder/subtractor front end:
// operand width, loader state encoding and debounce default.
package addsub_pkg;

    localparam int WIDTH               = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_RDY = 2'b10
    } state_t;

    // One's complement of the operand when subtracting.
    function automatic logic [WIDTH-1:0] cond_invert(
        input logic [WIDTH-1:0] v,
        input logic             m
    );
        return v ^ {WIDTH{m}};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter
// and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Registered pulse on the rising edge of the accepted level only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/operand_loader.sv
// Captures operand A, operand B and add/sub mode from switches on
// debounced button presses and presents them to the ripple adder.
module operand_loader
    import addsub_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_load,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] sw,
    input  logic             sw_mode,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             m_out,
    output logic             ops_valid,
    output logic [1:0]       state_out
);

    logic             w_load_press;
    logic             w_clear_press;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic             r_valid;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_load (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_load),
        .o_press (w_load_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clear),
        .o_press (w_clear_press)
    );

    // Operand sequencer: clear wins over load, illegal state recovers to S_A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_clear_press) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_load_press) begin
                        r_a     <= sw;
                        r_state <= S_B;
                        r_valid <= 1'b0;
                    end
                end
                S_B: begin
                    if (w_load_press) begin
                        r_b     <= sw;
                        r_m     <= sw_mode;
                        r_state <= S_RDY;
                        r_valid <= 1'b1;
                    end
                end
                S_RDY: begin
                    if (w_load_press) begin
                        r_a     <= sw;
                        r_state <= S_B;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_A;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_m     <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = cond_invert(r_b, r_m);
    assign m_out     = r_m;
    assign ops_valid = r_valid;
    assign state_out = r_state;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Front-end stage that feeds the 4-bit ripple adder/subtractor.
- Debounces two push-buttons and captures operand A, operand B and the add/subtract mode from board switches, in sequence.
- Presents the adder with a_out, b_out (already one's-complemented when subtracting) and m_out (carry-in), then flags ops_valid once both operands are held.

Parameters:
- WIDTH, 4, operand width; fixed to 4 to match the adder.
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised button level must differ from the stable level before it is accepted; minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- btn_load  input  1  raw, asynchronous "enter" push-button.
- btn_clear  input  1  raw, asynchronous "clear" push-button.
- sw  input  WIDTH  operand switches.
- sw_mode  input  1  0 = add, 1 = subtract.
- a_out  output  WIDTH  operand A to adder.
- b_out  output  WIDTH  B register XOR {WIDTH{m_out}}.
- m_out  output  1  latched mode, drives the adder carry-in.
- ops_valid  output  1  high while in S_RDY.
- state_out  output  2  current state encoding, for LEDs.

Behaviour:
- Reset (async, rst=1): state=S_A; a_reg, b_reg and m_reg = 0; a_out=0, b_out=0, m_out=0, ops_valid=0, state_out=2'b00; debounce synchronisers, counters and stable levels = 0. Reset asserted mid-sequence (S_B or S_RDY) discards all captured values.
- Debounce, one instance per button:
  - 2-flop synchroniser produces sync_q.
  - If sync_q == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync_q, cnt <= 0.
  - Else: cnt <= cnt+1.
  - press is a registered one-cycle pulse on the rising edge of stable.
  - A raw level held from the first sampling edge yields press high DEBOUNCE_CYCLES+3 edges later.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.
  - A held button produces exactly one press.
  - A release produces no pulse.
- FSM: S_A=2'b00, S_B=2'b01, S_RDY=2'b10; 2'b11 is illegal and recovers to S_A with registers cleared.
  - S_A, load_press: a_reg <= sw, go S_B.
  - S_B, load_press: b_reg <= sw, m_reg <= sw_mode, go S_RDY.
  - S_RDY, load_press: a_reg <= sw, go S_B. This starts a new operation; ops_valid drops the following cycle and b_reg/m_reg keep their old values until recaptured.
  - Any state, clear_press: a_reg, b_reg and m_reg cleared, go S_A. clear_press has priority over a simultaneous load_press.
- Outputs are registered or derived from registers only, with no combinational path from sw or sw_mode. b_out = b_reg ^ {WIDTH{m_reg}}. sw_mode changes outside the S_B capture have no effect.
- Captures occur on the edge where press=1. Outputs reflect the new value one cycle after the press pulse.

Decomposition:
- Package addsub_pkg holds WIDTH, the state typedef/localparams (S_A, S_B, S_RDY) and the DEBOUNCE_CYCLES default.
- Sub-module btn_debounce (synchroniser + counter + edge pulse), instantiated twice: for btn_load and btn_clear.
- The bench uses DEBOUNCE_CYCLES=4.

Test Plan:
- Add: rst; sw=0101, press load; sw=0011, sw_mode=0, press load -> a_out=0101, b_out=0011, m_out=0, ops_valid=1, state_out=10. Downstream adder gives sum=1000, c_out=0, v=1.
- Subtract: A=0101; B=0011 with sw_mode=1 -> b_out=1100, m_out=1. Adder gives sum=0010, c_out=1, v=0.
- Debounce: btn_load high for 3 cycles -> no capture, state stays 00. Held 40 cycles -> exactly one capture, press rising DEBOUNCE_CYCLES+3=7 edges after the first sample.
- Reset mid-op: rst asserted asynchronously while in S_B with a_reg=1010 -> immediately a_out=0000, state_out=00, ops_valid=0.
- Clear vs load: in S_RDY, btn_load and btn_clear pressed on the same cycle -> state S_A, all outputs 0.
- Restart: in S_RDY, sw=1111, press load -> a_out=1111, state_out=01, ops_valid=0; b_out retains its previous value.
